// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_W = 16;

  // Bit-counter width for a given operand width (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DIV_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Valid/ready operand and result bundle for seq_divider.
//   master: drives operands (I_VALID, I_DIVIDEND, I_DIVISOR) and result accept (I_READY)
//   slave : drives O_READY and the result (O_VALID, O_QUOT, O_REM, O_DIV0)
interface seq_divider_if #(
  parameter int unsigned W = 16
) ();

  logic         I_VALID;
  logic         O_READY;
  logic [W-1:0] I_DIVIDEND;
  logic [W-1:0] I_DIVISOR;
  logic         O_VALID;
  logic         I_READY;
  logic [W-1:0] O_QUOT;
  logic [W-1:0] O_REM;
  logic         O_DIV0;

  modport master (
    output I_VALID, I_DIVIDEND, I_DIVISOR, I_READY,
    input  O_READY, O_VALID, O_QUOT, O_REM, O_DIV0
  );

  modport slave (
    input  I_VALID, I_DIVIDEND, I_DIVISOR, I_READY,
    output O_READY, O_VALID, O_QUOT, O_REM, O_DIV0
  );

endinterface

// File: rtl/subtractor.sv
// N-bit ripple-borrow subtractor built from subtractor cells.
//   minuend, subtrahend : operands
//   difference          : minuend - subtrahend (mod 2^N)
//   borrow_out          : set when subtrahend > minuend
module subtractor #(
  parameter int unsigned N = 17
) (
  input  logic [N-1:0] minuend,
  input  logic [N-1:0] subtrahend,
  output logic [N-1:0] difference,
  output logic         borrow_out
);

  // Bit 0 acts as a half subtractor (no borrow-in); higher bits are full cells.
  always_comb begin
    logic borrow;
    borrow     = 1'b0;
    difference = '0;
    for (int i = 0; i < int'(N); i++) begin
      difference[i] = minuend[i] ^ subtrahend[i] ^ borrow;
      borrow        = (~minuend[i] & subtrahend[i]) |
                      (~(minuend[i] ^ subtrahend[i]) & borrow);
    end
    borrow_out = borrow;
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, one op in flight.
//   I_CLK, I_RST : clock, asynchronous active-high reset
//   bus (slave)  : operand accept (I_VALID/O_READY), result handshake (O_VALID/I_READY),
//                  O_QUOT, O_REM, O_DIV0 hold the last result until the next one lands
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic         I_CLK,
  input  logic         I_RST,
  seq_divider_if.slave bus
);

  localparam int unsigned CW = cnt_width(W);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   acc_q, acc_d;     // partial remainder
  logic [W-1:0]   qw_q, qw_d;       // quotient under construction
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dsr_q, dsr_d;
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   quot_q, quot_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           div0_q, div0_d;

  logic [W:0]     trial_min;
  logic [W:0]     diff;
  logic           borrow;
  logic           diff_msb_unused;
  logic [W-1:0]   acc_next;
  logic [W-1:0]   qw_next;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign trial_min = {acc_q, dvd_q[cnt_q]};

  subtractor #(.N(W + 1)) u_sub (
    .minuend    (trial_min),
    .subtrahend ({1'b0, dsr_q}),
    .difference (diff),
    .borrow_out (borrow)
  );

  // A non-borrowing difference is below the divisor, so its top bit is always zero.
  assign diff_msb_unused = diff[W];

  // State and datapath registers.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      qw_q    <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      qw_q    <= qw_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
    end
  end

  // Next-state, datapath step and registered-output updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    qw_d     = qw_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    div0_d   = div0_q;

    acc_next = borrow ? trial_min[W-1:0] : diff[W-1:0];
    qw_next  = qw_q;
    qw_next[cnt_q] = ~borrow;

    unique case (state_q)
      IDLE: begin
        if (bus.I_VALID) begin
          dvd_d   = bus.I_DIVIDEND;
          dsr_d   = bus.I_DIVISOR;
          acc_d   = '0;
          qw_d    = '0;
          ready_d = 1'b0;
          state_d = CALC;
          // Divide-by-zero runs a single pass so its result lands one edge after accept.
          cnt_d   = (bus.I_DIVISOR == '0) ? '0 : CW'(W - 1);
        end
      end
      CALC: begin
        acc_d = acc_next;
        qw_d  = qw_next;
        if (cnt_q == '0) begin
          state_d = DONE;
          valid_d = 1'b1;
          if (dsr_q == '0) begin
            quot_d = '1;
            rem_d  = dvd_q;
            div0_d = 1'b1;
          end else begin
            quot_d = qw_next;
            rem_d  = acc_next;
            div0_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (bus.I_READY) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign bus.O_READY = ready_q;
  assign bus.O_VALID = valid_q;
  assign bus.O_QUOT  = quot_q;
  assign bus.O_REM   = rem_q;
  assign bus.O_DIV0  = div0_q;

endmodule
